// File: rtl/l1_mem_responder_pkg.sv
// Shared definitions for the L1 line-transfer memory responder: state encoding
// and default geometry/latency used by l1_mem_responder and l1_mem_store.
package l1_mem_responder_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_RD_WAIT  = 3'd1;
   localparam state_t ST_RD_BURST = 3'd2;
   localparam state_t ST_WR_BURST = 3'd3;
   localparam state_t ST_WR_RESP  = 3'd4;

   localparam int DEF_BEATS  = 4;
   localparam int BEAT_W     = $clog2(DEF_BEATS);
   localparam int DEF_RD_LAT = 2;

endpackage

// File: rtl/l1_mem_store.sv
// Single-port synchronous word store backing the responder. Contents are never
// reset; only the registered read port clears so rdata starts at zero.
module l1_mem_store
   import l1_mem_responder_pkg::*;
#(
   parameter int DEPTH  = 4096,
   parameter int DATA_W = 32,
   parameter int IDX_W  = $clog2(DEPTH)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [IDX_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/l1_mem_responder.sv
// Memory-side responder for L1 line refills and writebacks.
// Define L1_RESP_CWF_EN to return refills critical-word-first.
module l1_mem_responder
   import l1_mem_responder_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int BEATS  = DEF_BEATS,
   parameter int DEPTH  = 4096,
   parameter int RD_LAT = DEF_RD_LAT
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              wdata_valid,
   input  logic [DATA_W-1:0] wdata,
   output logic              wdata_ready,
   output logic              rdata_valid,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_last,
   output logic              wr_done
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(BEATS);
   localparam int LINE_W = IDX_W - CNT_W;
   localparam logic [3:0]       LAT_LAST  = 4'((RD_LAT == 0) ? 0 : RD_LAT - 1);
   localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEATS - 1);

   state_t state;
   state_t next_state;

   logic              alive;
   logic [LINE_W-1:0] line_q;
   logic [CNT_W-1:0]  start_q;
   logic [CNT_W-1:0]  beat_cnt;
   logic [3:0]        lat_cnt;

   logic              accept;
   logic              issue_rd;
   logic              accept_wr;
   logic              rdata_valid_d;
   logic              rdata_last_d;
   logic              wr_done_d;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_addr;

   logic [LINE_W-1:0] req_line;
   logic [CNT_W-1:0]  req_off;
   logic              addr_unused;

   assign req_line = req_addr[IDX_W+1:CNT_W+2];
   assign req_off  = req_addr[CNT_W+1:2];

`ifdef L1_RESP_CWF_EN
   assign addr_unused = ^{req_addr[ADDR_W-1:IDX_W+2], req_addr[1:0]};
`else
   assign addr_unused = ^{req_addr[ADDR_W-1:IDX_W+2], req_off, req_addr[1:0]};
`endif

   // alive keeps req_ready low until the first clock after reset release
   assign req_ready   = alive && (state == ST_IDLE);
   assign wdata_ready = (state == ST_WR_BURST);
   assign accept      = req_valid && req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Burst and response states hold one extra cycle so the registered beat or
   // pulse is on the bus before the FSM reopens for the next request.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (req_write) begin
                  next_state = ST_WR_BURST;
               end else if (RD_LAT == 0) begin
                  next_state = ST_RD_BURST;
               end else begin
                  next_state = ST_RD_WAIT;
               end
            end
         end
         ST_RD_WAIT: begin
            if (lat_cnt == LAT_LAST) begin
               next_state = ST_RD_BURST;
            end
         end
         ST_RD_BURST: begin
            if (rdata_last) begin
               next_state = ST_IDLE;
            end
         end
         ST_WR_BURST: begin
            if (wdata_valid && (beat_cnt == BEAT_LAST)) begin
               next_state = ST_WR_RESP;
            end
         end
         ST_WR_RESP: begin
            if (wr_done) begin
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Store address runs one cycle ahead of the visible beat; writes use start 0.
   always_comb begin
      issue_rd      = (state == ST_RD_BURST) && !rdata_last;
      accept_wr     = (state == ST_WR_BURST) && wdata_valid;
      rdata_valid_d = issue_rd;
      rdata_last_d  = issue_rd && (beat_cnt == BEAT_LAST);
      wr_done_d     = (state == ST_WR_RESP) && !wr_done;
      mem_we        = accept_wr;
      mem_addr      = {line_q, CNT_W'(start_q + beat_cnt)};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alive       <= 1'b0;
         line_q      <= '0;
         start_q     <= '0;
         beat_cnt    <= '0;
         lat_cnt     <= '0;
         rdata_valid <= 1'b0;
         rdata_last  <= 1'b0;
         wr_done     <= 1'b0;
      end else begin
         alive       <= 1'b1;
         rdata_valid <= rdata_valid_d;
         rdata_last  <= rdata_last_d;
         wr_done     <= wr_done_d;
         if (accept) begin
            line_q   <= req_line;
            beat_cnt <= '0;
            lat_cnt  <= '0;
`ifdef L1_RESP_CWF_EN
            start_q  <= req_write ? '0 : req_off;
`else
            start_q  <= '0;
`endif
         end
         if (state == ST_RD_WAIT) begin
            lat_cnt <= lat_cnt + 4'd1;
         end
         if (issue_rd || accept_wr) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
         end
      end
   end

   l1_mem_store #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_store (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (wdata),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_l1_mem_responder.sv
// Directed self-checking bench for l1_mem_responder; expected refill order
// follows L1_RESP_CWF_EN when the macro is defined.
module tb_l1_mem_responder;

   localparam int RD_LAT = 2;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic        wdata_valid;
   logic [31:0] wdata;
   logic        wdata_ready;
   logic        rdata_valid;
   logic [31:0] rdata;
   logic        rdata_last;
   logic        wr_done;

   int checks = 0;
   int errors = 0;

   logic [3:0][31:0] line_a;
   logic [3:0][31:0] line_b;
   logic [3:0][31:0] line_c;
   logic [3:0][31:0] line_cwf;

   l1_mem_responder #(
      .ADDR_W (32),
      .DATA_W (32),
      .BEATS  (4),
      .DEPTH  (4096),
      .RD_LAT (RD_LAT)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .wdata_valid (wdata_valid),
      .wdata       (wdata),
      .wdata_ready (wdata_ready),
      .rdata_valid (rdata_valid),
      .rdata       (rdata),
      .rdata_last  (rdata_last),
      .wr_done     (wr_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkBit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic rv, input logic rw, input logic [31:0] ra,
                                input logic wv, input logic [31:0] wd);
      req_valid   = rv;
      req_write   = rw;
      req_addr    = ra;
      wdata_valid = wv;
      wdata       = wd;
   endtask

   // Writeback of one line; optional two-cycle wdata_valid gap after beat 1
   task automatic writeLine(input logic [31:0] addr, input logic [3:0][31:0] data, input bit gap);
      checkBit("wr_req_ready_pre", req_ready, 1'b1);
      applyStimulus(1'b1, 1'b1, addr, 1'b0, 32'h0);
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wdata_valid = 1'b1;
         wdata       = data[k];
         checkBit("wr_wdata_ready", wdata_ready, 1'b1);
         tick();
         wdata_valid = 1'b0;
         if (gap && k == 1) begin
            tick();
            checkBit("wr_gap_done", wr_done, 1'b0);
            tick();
         end
      end
      checkBit("wr_done_early", wr_done, 1'b0);
      checkBit("wr_req_ready_busy", req_ready, 1'b0);
      tick();
      checkBit("wr_done_pulse", wr_done, 1'b1);
      checkBit("wr_req_ready_resp", req_ready, 1'b0);
      checkBit("wr_wdata_ready_resp", wdata_ready, 1'b0);
      tick();
      checkBit("wr_done_clear", wr_done, 1'b0);
      checkBit("wr_req_ready_back", req_ready, 1'b1);
   endtask

   // Refill with expected beat order; hold keeps req_valid high with a new
   // address and pulses wdata_valid through the whole burst
   task automatic readLine(input logic [31:0] addr, input logic [3:0][31:0] exp,
                           input bit hold, input logic [31:0] hold_addr);
      checkBit("rd_req_ready_pre", req_ready, 1'b1);
      applyStimulus(1'b1, 1'b0, addr, 1'b0, 32'h0);
      tick();
      if (hold) begin
         req_addr    = hold_addr;
         wdata_valid = 1'b1;
         wdata       = 32'hDEAD_BEEF;
      end else begin
         req_valid = 1'b0;
      end
      for (int i = 0; i <= RD_LAT; i++) begin
         checkBit("rd_wait_valid", rdata_valid, 1'b0);
         checkBit("rd_wait_ready", req_ready, 1'b0);
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         checkBit("rd_beat_valid", rdata_valid, 1'b1);
         checkOutput("rd_beat_data", rdata, exp[k]);
         checkBit("rd_beat_last", rdata_last, (k == 3));
         checkBit("rd_beat_ready", req_ready, 1'b0);
         tick();
      end
      checkBit("rd_req_ready_back", req_ready, 1'b1);
      checkBit("rd_valid_after", rdata_valid, 1'b0);
      checkBit("rd_last_after", rdata_last, 1'b0);
      wdata_valid = 1'b0;
   endtask

   initial begin
      line_a = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
      line_b = {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
      line_c = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};
`ifdef L1_RESP_CWF_EN
      line_cwf = {line_a[2], line_a[1], line_a[0], line_a[3]};
`else
      line_cwf = line_a;
`endif

      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1 rst_n = 1'b0;
      #2;
      checkBit("rst_req_ready", req_ready, 1'b0);
      checkBit("rst_wdata_ready", wdata_ready, 1'b0);
      checkBit("rst_rdata_valid", rdata_valid, 1'b0);
      checkBit("rst_rdata_last", rdata_last, 1'b0);
      checkBit("rst_wr_done", wr_done, 1'b0);
      repeat (2) tick();
      checkBit("rst_req_ready_held", req_ready, 1'b0);
      checkOutput("rst_rdata", rdata, 32'h0);
      rst_n = 1'b1;
      tick();
      checkBit("post_rst_req_ready", req_ready, 1'b1);
      checkBit("post_rst_rdata_valid", rdata_valid, 1'b0);
      checkBit("post_rst_wr_done", wr_done, 1'b0);

      $display("[TB] preload line 0x100 and refill it");
      writeLine(32'h0000_0100, line_a, 1'b0);
      readLine(32'h0000_0100, line_a, 1'b0, 32'h0);

      $display("[TB] writeback 0x200 with gap, then immediate refill");
      writeLine(32'h0000_0200, line_b, 1'b1);
      readLine(32'h0000_0200, line_b, 1'b0, 32'h0);

      $display("[TB] refill with word offset 3");
      readLine(32'h0000_010C, line_cwf, 1'b0, 32'h0);

      $display("[TB] held request and stray wdata during refill");
      readLine(32'h0000_0100, line_a, 1'b1, 32'h0000_0200);
      readLine(32'h0000_0200, line_b, 1'b0, 32'h0);
      readLine(32'h0000_0100, line_a, 1'b0, 32'h0);

      $display("[TB] reset during refill beat 2");
      applyStimulus(1'b1, 1'b0, 32'h0000_0100, 1'b0, 32'h0);
      tick();
      req_valid = 1'b0;
      repeat (RD_LAT + 3) tick();
      checkBit("mid_beat2_valid", rdata_valid, 1'b1);
      checkOutput("mid_beat2_data", rdata, line_a[2]);
      rst_n = 1'b0;
      #1;
      checkBit("mid_rst_valid", rdata_valid, 1'b0);
      checkBit("mid_rst_last", rdata_last, 1'b0);
      checkBit("mid_rst_ready", req_ready, 1'b0);
      checkOutput("mid_rst_rdata", rdata, 32'h0);
      #2 rst_n = 1'b1;
      tick();
      checkBit("mid_post_ready", req_ready, 1'b1);
      checkBit("mid_post_valid", rdata_valid, 1'b0);
      readLine(32'h0000_0100, line_a, 1'b0, 32'h0);

      $display("[TB] address aliasing 0x4000 -> 0x0000");
      writeLine(32'h0000_4000, line_c, 1'b0);
      readLine(32'h0000_0000, line_c, 1'b0, 32'h0);
      readLine(32'h0000_0200, line_b, 1'b0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
